// File: rtl/pattern_det_ctrl_if.sv
// Host <-> detector bundle for pattern_det_ctrl: config, control, stream and status.
interface pattern_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    logic               Cfg_Load;
    logic [MAX_LEN-1:0] Cfg_Pattern;
    logic [3:0]         Cfg_Len;
    logic               Cfg_Overlap;
    logic [CNT_W-1:0]   Cfg_Target;
    logic               Start;
    logic               Abort;
    logic               In_Valid;
    logic               In;
    logic               Done_Ack;
    logic               Det;
    logic [CNT_W-1:0]   Count;
    logic               Busy;
    logic               Done;
    logic               Cfg_Err;
    logic [1:0]         state;

    modport master (
        output Cfg_Load, Cfg_Pattern, Cfg_Len, Cfg_Overlap, Cfg_Target,
        output Start, Abort, In_Valid, In, Done_Ack,
        input  Det, Count, Busy, Done, Cfg_Err, state
    );

    modport slave (
        input  Cfg_Load, Cfg_Pattern, Cfg_Len, Cfg_Overlap, Cfg_Target,
        input  Start, Abort, In_Valid, In, Done_Ack,
        output Det, Count, Busy, Done, Cfg_Err, state
    );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Programmable serial sequence detector: loadable pattern/length/overlap/target,
// per-match Det pulse, match counter and held Done until acknowledged.
module pattern_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    pattern_det_ctrl_if.slave bus
);
    localparam int FW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [3:0]         len_q, len_d;
    logic               ov_q, ov_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               det_q, det_d;
    logic               err_q, err_d;

    logic               len_ok, cfg_wr, go, shift_en;
    logic [MAX_LEN-1:0] hist_sh, mask;
    logic [FW-1:0]      fill_inc;
    logic               fill_ok, pat_eq, match, reach;
    logic [CNT_W-1:0]   cnt_inc;
    logic               busy, done;

    // Match is evaluated on the post-shift history so Det lands one clock after the bit.
    always_comb begin
        len_ok   = (bus.Cfg_Len != 4'd0) && (int'(bus.Cfg_Len) <= MAX_LEN);
        cfg_wr   = (state_q == S_IDLE) && bus.Cfg_Load;
        go       = (state_q == S_IDLE) && bus.Start && !bus.Cfg_Load;
        shift_en = (state_q == S_RUN) && bus.In_Valid && !bus.Abort;
        hist_sh  = {hist_q[MAX_LEN-2:0], bus.In};
        fill_inc = (fill_q == FW'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        fill_ok  = int'(fill_inc) >= int'(len_q);
        pat_eq   = ((hist_sh ^ pat_q) & mask) == '0;
        match    = shift_en && fill_ok && pat_eq;
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        reach    = match && (tgt_q != '0) && (cnt_inc == tgt_q);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_RUN;
            S_RUN: begin
                if (bus.Abort)  state_d = S_IDLE;
                else if (reach) state_d = S_DONE;
            end
            S_DONE: if (bus.Done_Ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ov_d   = ov_q;
        tgt_d  = tgt_q;
        err_d  = err_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        det_d  = 1'b0;
        if (cfg_wr) begin
            if (len_ok) begin
                pat_d = bus.Cfg_Pattern;
                len_d = bus.Cfg_Len;
                ov_d  = bus.Cfg_Overlap;
                tgt_d = bus.Cfg_Target;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (go) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end
        if (shift_en) begin
            hist_d = hist_sh;
            fill_d = fill_inc;
            if (match) begin
                det_d = 1'b1;
                cnt_d = cnt_inc;
                // Non-overlapping mode needs a full fresh pattern after each hit.
                if (!ov_q) fill_d = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pat_q  <= '0;
            len_q  <= 4'd1;
            ov_q   <= 1'b0;
            tgt_q  <= '0;
            err_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            det_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ov_q   <= ov_d;
            tgt_q  <= tgt_d;
            err_q  <= err_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            det_q  <= det_d;
        end
    end

    assign bus.Det     = det_q;
    assign bus.Count   = cnt_q;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Cfg_Err = err_q;
    assign bus.state   = (state_q == 2'd3) ? S_IDLE : state_q;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed + randomized bench for pattern_det_ctrl against a bit-stream reference model.
module tb_pattern_det_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_fail;

    pattern_det_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    pattern_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: the stream since Start plus the index where matching restarts.
    int         m_state, m_cnt, m_len, m_tgt, anchor;
    bit         m_ov, m_det;
    bit [7:0]   m_pat;
    bit         strm[$];

    function automatic bit ref_hit();
        int n = strm.size();
        if (n - anchor < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (strm[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_det"},   32'(bus.Det),   32'(m_det));
        chk({tag, "_count"}, 32'(bus.Count), 32'(m_cnt));
        chk({tag, "_state"}, 32'(bus.state), 32'(m_state));
        chk({tag, "_busy"},  32'(bus.Busy),  32'(m_state == 1));
        chk({tag, "_done"},  32'(bus.Done),  32'(m_state == 2));
    endtask

    task automatic load(input bit [7:0] p, input int len, input bit ov, input int tgt);
        bus.Cfg_Pattern = p;
        bus.Cfg_Len     = 4'(len);
        bus.Cfg_Overlap = ov;
        bus.Cfg_Target  = CNT_W'(tgt);
        bus.Cfg_Load    = 1'b1;
        step();
        bus.Cfg_Load    = 1'b0;
        if (len >= 1 && len <= MAX_LEN) begin
            m_pat = p; m_len = len; m_ov = ov; m_tgt = tgt;
        end
        chk("cfg_err", 32'(bus.Cfg_Err), 32'(!(len >= 1 && len <= MAX_LEN)));
    endtask

    task automatic start();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        strm.delete();
        anchor = 0; m_cnt = 0; m_state = 1; m_det = 0;
        chk_all("start");
    endtask

    task automatic bitc(input bit v, input bit b, input bit ab);
        bus.In_Valid = v;
        bus.In       = b;
        bus.Abort    = ab;
        step();
        bus.In_Valid = 1'b0;
        bus.Abort    = 1'b0;
        m_det = 0;
        if (m_state == 1) begin
            if (ab) m_state = 0;
            else if (v) begin
                strm.push_back(b);
                if (ref_hit()) begin
                    m_det = 1;
                    if (m_cnt < MAXC) m_cnt++;
                    if (!m_ov) anchor = strm.size();
                    if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
                end
            end
        end
        chk_all("bit");
    endtask

    task automatic ack();
        bus.Done_Ack = 1'b1;
        step();
        bus.Done_Ack = 1'b0;
        if (m_state == 2) m_state = 0;
        m_det = 0;
        chk_all("ack");
    endtask

    task automatic feed(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bitc(1'b1, bits[i], 1'b0);
    endtask

    initial begin
        bit [7:0] rp;
        int rl, rt;
        bit ro;
        n_cmp = 0; n_fail = 0;
        m_state = 0; m_cnt = 0; m_len = 1; m_tgt = 0; m_ov = 0; m_pat = 0; anchor = 0; m_det = 0;
        bus.Cfg_Load = 0; bus.Cfg_Pattern = 0; bus.Cfg_Len = 0; bus.Cfg_Overlap = 0;
        bus.Cfg_Target = 0; bus.Start = 0; bus.Abort = 0; bus.In_Valid = 0; bus.In = 0;
        bus.Done_Ack = 0;
        Rst = 1'b0;
        repeat (3) step();
        Rst = 1'b1;
        step();
        chk_all("reset");
        chk("reset_err", 32'(bus.Cfg_Err), 0);

        // Non-overlapping 1010
        load(8'b1010, 4, 1'b0, 0);
        start();
        feed(16'b1010101010, 10);
        chk("nonov_count", 32'(bus.Count), 2);
        bitc(1'b0, 1'b0, 1'b1);

        // Overlapping 1010
        load(8'b1010, 4, 1'b1, 0);
        start();
        feed(16'b1010101010, 10);
        chk("ov_count", 32'(bus.Count), 4);
        bitc(1'b0, 1'b0, 1'b1);

        // Target 3 with gaps, then ignored bit and ack
        load(8'b11, 2, 1'b1, 3);
        start();
        bitc(1, 1, 0); bitc(0, 0, 0); bitc(1, 1, 0); bitc(0, 1, 0);
        bitc(1, 1, 0); bitc(0, 0, 0); bitc(0, 0, 0); bitc(1, 1, 0);
        chk("tgt_done", 32'(bus.Done), 1);
        chk("tgt_state", 32'(bus.state), 2);
        bitc(1, 1, 0);
        chk("tgt_hold", 32'(bus.Count), 3);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk("done_start_ign", 32'(bus.state), 2);
        ack();
        chk("ack_count", 32'(bus.Count), 3);

        // Rejected loads keep the 11/len2 config
        load(8'hF0, 0, 1'b0, 0);
        load(8'hF0, 9, 1'b0, 0);
        start();
        feed(16'b11, 2);
        chk("err_keep_count", 32'(bus.Count), 1);
        bitc(0, 0, 1);
        load(8'b110, 3, 1'b0, 0);
        start();
        bus.Cfg_Pattern = 8'b111; bus.Cfg_Len = 4'd3; bus.Cfg_Load = 1'b1;
        bitc(1, 1, 0);
        bus.Cfg_Load = 1'b0;
        chk("run_load_noerr", 32'(bus.Cfg_Err), 0);
        feed(16'b10111110, 8);
        bitc(0, 0, 1);

        // Abort on the completing bit
        load(8'b1010, 4, 1'b0, 0);
        start();
        feed(16'b101, 3);
        bitc(1, 0, 1);
        chk("abort_det", 32'(bus.Det), 0);
        chk("abort_count", 32'(bus.Count), 0);
        chk("abort_state", 32'(bus.state), 0);

        // Counter saturation with target 0
        load(8'b1, 1, 1'b0, 0);
        start();
        for (int i = 0; i < 260; i++) bitc(1, 1, 0);
        chk("sat_count", 32'(bus.Count), MAXC);
        bitc(0, 0, 1);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            rp = 8'($urandom);
            rl = $urandom_range(1, 5);
            ro = 1'($urandom);
            rt = $urandom_range(0, 4);
            load(rp, rl, ro, rt);
            start();
            for (int c = 0; c < 150; c++) begin
                if (m_state == 2) begin ack(); break; end
                if ($urandom_range(0, 79) == 0) begin bitc(1'($urandom), 1'($urandom), 1'b1); break; end
                bitc(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0);
            end
            if (m_state == 1) bitc(0, 0, 1);
            if (m_state == 2) ack();
        end

        // Asynchronous reset mid-run after two matches
        load(8'b11, 2, 1'b1, 0);
        start();
        feed(16'b111, 3);
        #2 Rst = 1'b0;
        #1;
        m_state = 0; m_cnt = 0; m_det = 0; m_pat = 0; m_len = 1; m_ov = 0; m_tgt = 0;
        chk_all("rst_mid");
        chk("rst_mid_err", 32'(bus.Cfg_Err), 0);
        #2 Rst = 1'b1;
        step();
        start();
        bitc(1, 1, 0);
        bitc(1, 0, 0);
        chk("rst_len1_count", 32'(bus.Count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
